cp_dmem_bus_arbiter: RTL and testbench

Two-requester arbiter and burst sequencer for the bus-side port (port A) of the control-processor data memory. It grants the port to the host loader (requester 0) or the PE-array DMA (requester 1), then issues word accesses with auto-incrementing addresses. It routes the 1-cycle-latency read data back to the granted requester. Core-side port B is untouched.

---
 rtl/cp_dmem_bus_arbiter_pkg.sv | 19 +
 rtl/cp_dmem_bus_arbiter_if.sv | 27 ++
 rtl/cp_dmem_bus_arbiter_rr.sv | 13 +
 rtl/cp_dmem_bus_arbiter.sv | 111 +++++++++++
 tb/tb_cp_dmem_bus_arbiter.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cp_dmem_bus_arbiter_pkg.sv
// Shared definitions for the control-processor data-memory bus-port arbiter:
// default widths, FSM state encoding and the two-way priority pick.
package cp_dmem_bus_arbiter_pkg;

   localparam int DEF_CP_D_MEM_ADDR_WIDTH = 10;
   localparam int DEF_CP_DATA_WIDTH       = 32;
   localparam int DEF_CP_DMEM_BURST_BITS  = 4;

   typedef enum logic {
      CP_DMEM_ARB_IDLE  = 1'b0,
      CP_DMEM_ARB_BURST = 1'b1
   } arbState_t;

   // A lone requester always wins; on contention the priority pointer decides.
   function automatic logic rrPick(input logic req0, input logic req1, input logic prio);
      return (req0 && req1) ? prio : req1;
   endfunction

endpackage

// File: rtl/cp_dmem_bus_arbiter_if.sv
// Requester channel into the data-memory bus arbiter: burst request,
// per-beat write data, beat-issued handshake and read-return strobe.
interface cp_dmem_bus_arbiter_if
   import cp_dmem_bus_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_CP_D_MEM_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEF_CP_DATA_WIDTH,
   parameter int BURST_BITS = DEF_CP_DMEM_BURST_BITS
);
   logic                  valid;
   logic                  write;
   logic [ADDR_WIDTH-1:0] address;
   logic [BURST_BITS-1:0] burstLen;
   logic [DATA_WIDTH-1:0] writeData;
   logic                  ready;
   logic                  readValid;

   modport master (
      output valid, write, address, burstLen, writeData,
      input  ready, readValid
   );

   modport slave (
      input  valid, write, address, burstLen, writeData,
      output ready, readValid
   );
endinterface

// File: rtl/cp_dmem_bus_arbiter_rr.sv
// Two-way round-robin grant; the priority pointer itself lives with the FSM.
module cp_dmem_bus_arbiter_rr
   import cp_dmem_bus_arbiter_pkg::*;
(
   input  logic iReq0,
   input  logic iReq1,
   input  logic iPrio,
   output logic oGrantValid,
   output logic oGrantId
);
   assign oGrantValid = iReq0 || iReq1;
   assign oGrantId    = rrPick(iReq0, iReq1, iPrio);
endmodule

// File: rtl/cp_dmem_bus_arbiter.sv
// Arbiter and burst sequencer for data-memory port A: grants host loader or
// PE-array DMA, issues auto-incrementing word beats, routes read data back.
module cp_dmem_bus_arbiter
   import cp_dmem_bus_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_CP_D_MEM_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEF_CP_DATA_WIDTH,
   parameter int BURST_BITS = DEF_CP_DMEM_BURST_BITS
) (
   input  logic                  iClk,
   input  logic                  iReset_n,
   cp_dmem_bus_arbiter_if.slave  req0,
   cp_dmem_bus_arbiter_if.slave  req1,
   output logic [DATA_WIDTH-1:0] oReq_Read_Data,
   output logic                  oBus_Valid,
   output logic                  oBus_Write_Enable,
   output logic [ADDR_WIDTH-1:0] oBus_Address,
   output logic [DATA_WIDTH-1:0] oBus_Write_Data,
   input  logic [DATA_WIDTH-1:0] iBus_Read_Data
);
   localparam int WORD_W = ADDR_WIDTH - 2;

   arbState_t             state;
   logic                  owner;
   logic                  ownerWrite;
   logic                  prio;
   logic                  rdPend;
   logic                  rdOwner;
   logic [WORD_W-1:0]     wordAddr;
   logic [BURST_BITS-1:0] beatsLeft;

   logic                  grantValid;
   logic                  grantId;
   logic                  ownerValid;
   logic                  issue;
   logic [DATA_WIDTH-1:0] ownerData;
   logic [3:0]            unusedAddrLsbs;

   cp_dmem_bus_arbiter_rr u_rr (
      .iReq0       (req0.valid),
      .iReq1       (req1.valid),
      .iPrio       (prio),
      .oGrantValid (grantValid),
      .oGrantId    (grantId)
   );

   assign unusedAddrLsbs = {req0.address[1:0], req1.address[1:0]};

   assign ownerValid = owner ? req1.valid : req0.valid;
   assign ownerData  = owner ? req1.writeData : req0.writeData;
   assign issue      = (state == CP_DMEM_ARB_BURST) && ownerValid;

   assign req0.ready     = issue && !owner;
   assign req1.ready     = issue && owner;
   assign req0.readValid = rdPend && !rdOwner;
   assign req1.readValid = rdPend && rdOwner;
   assign oReq_Read_Data = rdPend ? iBus_Read_Data : '0;

   always_ff @(posedge iClk or negedge iReset_n) begin
      if (!iReset_n) begin
         state             <= CP_DMEM_ARB_IDLE;
         owner             <= 1'b0;
         ownerWrite        <= 1'b0;
         prio              <= 1'b0;
         wordAddr          <= '0;
         beatsLeft         <= '0;
         rdPend            <= 1'b0;
         rdOwner           <= 1'b0;
         oBus_Valid        <= 1'b0;
         oBus_Write_Enable <= 1'b0;
         oBus_Address      <= '0;
         oBus_Write_Data   <= '0;
      end else begin
         oBus_Valid        <= issue;
         oBus_Write_Enable <= issue && ownerWrite;
         if (issue) begin
            oBus_Address    <= {wordAddr, 2'b00};
            oBus_Write_Data <= ownerData;
         end

         // owner only changes on a grant edge, which follows the last bus beat,
         // so the tag sampled here still names the requester of that beat
         rdPend  <= oBus_Valid && !oBus_Write_Enable;
         rdOwner <= owner;

         case (state)
            CP_DMEM_ARB_IDLE: begin
               if (grantValid) begin
                  owner      <= grantId;
                  ownerWrite <= grantId ? req1.write : req0.write;
                  wordAddr   <= grantId ? req1.address[ADDR_WIDTH-1:2]
                                        : req0.address[ADDR_WIDTH-1:2];
                  beatsLeft  <= grantId ? req1.burstLen : req0.burstLen;
                  state      <= CP_DMEM_ARB_BURST;
               end
            end
            CP_DMEM_ARB_BURST: begin
               if (issue) begin
                  wordAddr  <= wordAddr + 1'b1;
                  beatsLeft <= beatsLeft - 1'b1;
                  if (beatsLeft == '0) begin
                     state <= CP_DMEM_ARB_IDLE;
                     prio  <= ~owner;
                  end
               end
            end
            default: state <= CP_DMEM_ARB_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_cp_dmem_bus_arbiter.sv
// Randomized bench for cp_dmem_bus_arbiter: two burst requesters, a 1-cycle
// memory, and a transaction-level reference for grants, beats and read data.
`timescale 1ns/1ps
module tb_cp_dmem_bus_arbiter;
   import cp_dmem_bus_arbiter_pkg::*;

   localparam int AW    = 10;
   localparam int DW    = 32;
   localparam int BB    = 4;
   localparam int WW    = AW - 2;
   localparam int WORDS = 1 << WW;

   logic          iClk = 1'b0;
   logic          iReset_n = 1'b0;
   logic [DW-1:0] oReq_Read_Data;
   logic          oBus_Valid;
   logic          oBus_Write_Enable;
   logic [AW-1:0] oBus_Address;
   logic [DW-1:0] oBus_Write_Data;
   logic [DW-1:0] iBus_Read_Data;

   cp_dmem_bus_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_BITS(BB)) req0If ();
   cp_dmem_bus_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_BITS(BB)) req1If ();

   cp_dmem_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_BITS(BB)) dut (
      .iClk              (iClk),
      .iReset_n          (iReset_n),
      .req0              (req0If),
      .req1              (req1If),
      .oReq_Read_Data    (oReq_Read_Data),
      .oBus_Valid        (oBus_Valid),
      .oBus_Write_Enable (oBus_Write_Enable),
      .oBus_Address      (oBus_Address),
      .oBus_Write_Data   (oBus_Write_Data),
      .iBus_Read_Data    (iBus_Read_Data)
   );

   always #5 iClk = ~iClk;

   function automatic logic [DW-1:0] initWord(input int w);
      return 32'hC0DE0000 ^ (w * 32'h00010203);
   endfunction

   // memory behind port A: writes land at the edge, reads return one cycle later
   logic [DW-1:0] mem [WORDS];
   bit            written [WORDS];
   always @(posedge iClk) begin
      if (oBus_Valid) begin
         if (oBus_Write_Enable) begin
            mem[oBus_Address[AW-1:2]]     <= oBus_Write_Data;
            written[oBus_Address[AW-1:2]] <= 1'b1;
         end else begin
            iBus_Read_Data <= written[oBus_Address[AW-1:2]] ? mem[oBus_Address[AW-1:2]]
                                                            : initWord(int'(oBus_Address[AW-1:2]));
         end
      end
   end

   int errors = 0;
   int checks = 0;

   task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // requester-side burst state
   bit            act [2];
   bit            wrB [2];
   int            lenB [2];
   int            done [2];
   int            gap [2];
   int            stall [2];
   logic [WW-1:0] startW [2];
   logic [1:0]    lsb [2];
   logic [DW-1:0] wd [2][16];
   logic          v [2];

   // reference: arbiter occupancy, expected bus beat and read return
   logic [DW-1:0] refMem [WORDS];
   bit            mIdle = 1'b1;
   bit            mOwner;
   bit            mPrio = 1'b0;
   int            mLeft;
   bit            pbV, pbWe, pbOwner;
   logic [AW-1:0] pbAddr;
   logic [DW-1:0] pbData;
   bit            rvV, rvOwner;
   logic [DW-1:0] rvData;
   int            nRst = 0;

   task automatic genReq(input int r);
      if (!act[r]) begin
         if (gap[r] > 0) gap[r]--;
         else begin
            act[r]   = 1'b1;
            done[r]  = 0;
            stall[r] = 0;
            wrB[r]   = 1'($urandom_range(0, 1));
            lenB[r]  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 3));
            startW[r] = ($urandom_range(0, 5) == 0) ? WW'(WORDS - 1 - int'($urandom_range(0, 1)))
                                                    : WW'($urandom_range(0, WORDS - 1));
            lsb[r] = 2'($urandom_range(0, 3));
            for (int i = 0; i < 16; i++) wd[r][i] = $urandom;
         end
      end
      if (act[r] && stall[r] > 0) begin
         stall[r]--;
         v[r] = 1'b0;
      end else if (act[r] && done[r] > 0 && $urandom_range(0, 7) == 0) begin
         stall[r] = int'($urandom_range(0, 2));
         v[r] = 1'b0;
      end else begin
         v[r] = act[r];
      end
   endtask

   task automatic driveReqs();
      req0If.valid     = v[0];
      req0If.write     = wrB[0];
      req0If.address   = {startW[0], lsb[0]};
      req0If.burstLen  = BB'(lenB[0]);
      req0If.writeData = wd[0][done[0] % 16];
      req1If.valid     = v[1];
      req1If.write     = wrB[1];
      req1If.address   = {startW[1], lsb[1]};
      req1If.burstLen  = BB'(lenB[1]);
      req1If.writeData = wd[1][done[1] % 16];
   endtask

   task automatic checkAllZero(input string pfx);
      checkVal({pfx, "BusValid"}, 64'(oBus_Valid), 64'd0);
      checkVal({pfx, "BusWe"}, 64'(oBus_Write_Enable), 64'd0);
      checkVal({pfx, "BusAddr"}, 64'(oBus_Address), 64'd0);
      checkVal({pfx, "BusWdata"}, 64'(oBus_Write_Data), 64'd0);
      checkVal({pfx, "Ready0"}, 64'(req0If.ready), 64'd0);
      checkVal({pfx, "Ready1"}, 64'(req1If.ready), 64'd0);
      checkVal({pfx, "RdValid0"}, 64'(req0If.readValid), 64'd0);
      checkVal({pfx, "RdValid1"}, 64'(req1If.readValid), 64'd0);
      checkVal({pfx, "RdData"}, 64'(oReq_Read_Data), 64'd0);
   endtask

   task automatic advance(input int r);
      done[r]++;
      if (done[r] > lenB[r]) begin
         act[r] = 1'b0;
         gap[r] = int'($urandom_range(0, 3));
      end
   endtask

   task automatic stepModel();
      bit            e0, e1, nrvV, nrvOwner;
      logic [DW-1:0] nrvData;
      checkVal("busValid", 64'(oBus_Valid), 64'(pbV));
      if (pbV) begin
         checkVal("busAddr", 64'(oBus_Address), 64'(pbAddr));
         checkVal("busWe", 64'(oBus_Write_Enable), 64'(pbWe));
         if (pbWe) checkVal("busWdata", 64'(oBus_Write_Data), 64'(pbData));
      end
      checkVal("rdValid0", 64'(req0If.readValid), 64'(rvV && !rvOwner));
      checkVal("rdValid1", 64'(req1If.readValid), 64'(rvV && rvOwner));
      if (rvV) checkVal("rdData", 64'(oReq_Read_Data), 64'(rvData));

      nrvV     = pbV && !pbWe;
      nrvOwner = pbOwner;
      nrvData  = refMem[pbAddr[AW-1:2]];
      if (pbV && pbWe) refMem[pbAddr[AW-1:2]] = pbData;

      e0 = 1'b0;
      e1 = 1'b0;
      if (mIdle) begin
         if (v[0] || v[1]) begin
            mOwner = (v[0] && v[1]) ? mPrio : v[1];
            mLeft  = lenB[mOwner] + 1;
            mIdle  = 1'b0;
         end
      end else if (v[mOwner]) begin
         if (mOwner) e1 = 1'b1;
         else e0 = 1'b1;
         mLeft--;
         if (mLeft == 0) begin
            mIdle = 1'b1;
            mPrio = !mOwner;
         end
      end
      checkVal("ready0", 64'(req0If.ready), 64'(e0));
      checkVal("ready1", 64'(req1If.ready), 64'(e1));

      pbV = e0 || e1;
      if (pbV) begin
         pbOwner = mOwner;
         pbWe    = wrB[mOwner];
         pbAddr  = {WW'(startW[mOwner] + WW'(done[mOwner])), 2'b00};
         pbData  = wd[mOwner][done[mOwner] % 16];
      end
      rvV     = nrvV;
      rvOwner = nrvOwner;
      rvData  = nrvData;

      if (req0If.ready) advance(0);
      if (req1If.ready) advance(1);
   endtask

   task automatic doReset();
      iReset_n = 1'b0;
      #1;
      checkAllZero("midRst");
      mIdle = 1'b1;
      mPrio = 1'b0;
      pbV   = 1'b0;
      rvV   = 1'b0;
      for (int r = 0; r < 2; r++) begin
         act[r] = 1'b0;
         gap[r] = 0;
         v[r]   = 1'b0;
      end
      driveReqs();
      @(posedge iClk);
      @(posedge iClk);
      @(negedge iClk);
      iReset_n = 1'b1;
   endtask

   initial begin
      for (int i = 0; i < WORDS; i++) refMem[i] = initWord(i);
      for (int r = 0; r < 2; r++) begin
         act[r] = 1'b0; gap[r] = 0; done[r] = 0; stall[r] = 0; lenB[r] = 0;
         wrB[r] = 1'b0; startW[r] = '0; lsb[r] = '0; v[r] = 1'b0;
         for (int i = 0; i < 16; i++) wd[r][i] = '0;
      end
      pbV = 1'b0; rvV = 1'b0; pbWe = 1'b0; pbOwner = 1'b0; pbAddr = '0; pbData = '0;
      rvOwner = 1'b0; rvData = '0; mOwner = 1'b0; mLeft = 0;
      driveReqs();
      repeat (3) @(posedge iClk);
      #1;
      checkAllZero("rst");
      @(negedge iClk);
      iReset_n = 1'b1;

      // both requesters start at once after reset, so the first grant is a contention case
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge iClk);
         genReq(0);
         genReq(1);
         driveReqs();
         #1;
         if (((cyc > 800 && nRst == 0) || (cyc > 2000 && nRst == 1)) && !mIdle && mLeft > 2) begin
            nRst++;
            doReset();
         end else begin
            stepModel();
         end
      end
      checkVal("resetsDone", 64'(nRst), 64'd2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
